// File: rtl/pspwm_cfg_pkg.sv
// rtl/pspwm_cfg_pkg.sv - shared types and constants for the PSPWM configuration master
// Contents: FSM state enum, err_code values, AXI response codes, register stride.
package pspwm_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BRESP    = 2'd1;
  localparam logic [1:0] ERR_RRESP    = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;

  localparam int REG_STRIDE = 4;

endpackage

// File: rtl/pspwm_cfg_master.sv
// rtl/pspwm_cfg_master.sv - AXI4-Lite master that loads (and optionally reads back) the PSPWM register bank
// Ports:
//   m00_axi_aclk / m00_axi_aresetn : clock, asynchronous active-low reset
//   start, verify_en, base_addr, cfg_data : sequence request, sampled on an accepted start
//   busy, done, error, err_code, err_index : sequence status
//   m00_axi_aw*/w*/b*/ar*/r* : AXI4-Lite master channels, one transaction outstanding at a time
module pspwm_cfg_master
  import pspwm_cfg_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     m00_axi_aclk,
  input  logic                     m00_axi_aresetn,
  input  logic                     start,
  input  logic                     verify_en,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [NREG*DATA_W-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [3:0]               err_index,
  output logic [ADDR_W-1:0]        m00_axi_awaddr,
  output logic [2:0]               m00_axi_awprot,
  output logic                     m00_axi_awvalid,
  input  logic                     m00_axi_awready,
  output logic [DATA_W-1:0]        m00_axi_wdata,
  output logic [3:0]               m00_axi_wstrb,
  output logic                     m00_axi_wvalid,
  input  logic                     m00_axi_wready,
  input  logic [1:0]               m00_axi_bresp,
  input  logic                     m00_axi_bvalid,
  output logic                     m00_axi_bready,
  output logic [ADDR_W-1:0]        m00_axi_araddr,
  output logic [2:0]               m00_axi_arprot,
  output logic                     m00_axi_arvalid,
  input  logic                     m00_axi_arready,
  input  logic [DATA_W-1:0]        m00_axi_rdata,
  input  logic [1:0]               m00_axi_rresp,
  input  logic                     m00_axi_rvalid,
  output logic                     m00_axi_rready
);

  localparam logic [3:0] IDX_LAST = 4'(NREG - 1);

  state_e                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [NREG*DATA_W-1:0] cfg_q, cfg_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic                   verify_q, verify_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [3:0]             err_index_q, err_index_d;

  logic [ADDR_W-1:0]      reg_addr;
  logic [DATA_W-1:0]      reg_data;
  logic                   aw_ok;
  logic                   w_ok;

  // Current register word, selected from the latched configuration.
  always_comb begin
    reg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_q == 4'(i)) begin
        reg_data = cfg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Wraps modulo 2^ADDR_W by construction.
  assign reg_addr = base_q + ADDR_W'(idx_q) * ADDR_W'(REG_STRIDE);

  // State register
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cfg_q       <= '0;
      base_q      <= '0;
      verify_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      base_q      <= base_d;
      verify_q    <= verify_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_d       = cfg_q;
    base_d      = base_q;
    verify_d    = verify_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    // AW and W complete independently; a channel counts as done once it has
    // handshaken in this or any earlier WRITE cycle.
    aw_ok       = aw_done_q || (m00_axi_awvalid && m00_axi_awready);
    w_ok        = w_done_q || (m00_axi_wvalid && m00_axi_wready);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d       = cfg_data;
          base_d      = base_addr;
          verify_d    = verify_en;
          idx_d       = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          err_code_d  = ERR_NONE;
          err_index_d = '0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (aw_ok && w_ok) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRESP;
        end else begin
          aw_done_d = aw_ok;
          w_done_d  = w_ok;
        end
      end
      ST_WRESP: begin
        if (m00_axi_bvalid) begin
          if (m00_axi_bresp == RESP_OKAY) begin
            state_d = verify_q ? ST_READ : ST_NEXT;
          end else begin
            err_code_d  = ERR_BRESP;
            err_index_d = idx_q;
            state_d     = ST_ERR;
          end
        end
      end
      ST_READ: begin
        if (m00_axi_arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m00_axi_rvalid) begin
          if (m00_axi_rresp != RESP_OKAY) begin
            err_code_d  = ERR_RRESP;
            err_index_d = idx_q;
            state_d     = ST_ERR;
          end else if (m00_axi_rdata != reg_data) begin
            err_code_d  = ERR_MISMATCH;
            err_index_d = idx_q;
            state_d     = ST_ERR;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: valids come straight from state so a reset drops them at once.
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    m00_axi_awvalid = 1'b0;
    m00_axi_wvalid  = 1'b0;
    m00_axi_bready  = 1'b0;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        busy            = 1'b1;
        m00_axi_awvalid = !aw_done_q;
        m00_axi_wvalid  = !w_done_q;
      end
      ST_WRESP: begin
        busy           = 1'b1;
        m00_axi_bready = 1'b1;
      end
      ST_READ: begin
        busy            = 1'b1;
        m00_axi_arvalid = 1'b1;
      end
      ST_RDATA: begin
        busy           = 1'b1;
        m00_axi_rready = 1'b1;
      end
      ST_NEXT:  busy  = 1'b1;
      ST_DONE:  done  = 1'b1;
      ST_ERR:   error = 1'b1;
      default:  ;
    endcase
  end

  assign m00_axi_awaddr = reg_addr;
  assign m00_axi_araddr = reg_addr;
  assign m00_axi_wdata  = reg_data;
  assign m00_axi_wstrb  = 4'hF;
  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign err_code       = err_code_q;
  assign err_index      = err_index_q;

endmodule

// File: tb/tb_pspwm_cfg_master.sv
// tb/tb_pspwm_cfg_master.sv - directed self-checking bench for pspwm_cfg_master
module tb_pspwm_cfg_master;
  import pspwm_cfg_pkg::*;

  localparam int          NREG = 4;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               verify_en = 1'b0;
  logic [31:0]        base_addr = BASE;
  logic [NREG*32-1:0] cfg_data;
  logic [31:0]        exp_w [4];

  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  err_index;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  pspwm_cfg_master #(.NREG(NREG), .ADDR_W(32), .DATA_W(32)) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(rst_n),
    .start          (start),
    .verify_en      (verify_en),
    .base_addr      (base_addr),
    .cfg_data       (cfg_data),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .err_index      (err_index),
    .m00_axi_awaddr (awaddr),
    .m00_axi_awprot (awprot),
    .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata  (wdata),
    .m00_axi_wstrb  (wstrb),
    .m00_axi_wvalid (wvalid),
    .m00_axi_wready (wready),
    .m00_axi_bresp  (bresp),
    .m00_axi_bvalid (bvalid),
    .m00_axi_bready (bready),
    .m00_axi_araddr (araddr),
    .m00_axi_arprot (arprot),
    .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready),
    .m00_axi_rdata  (rdata),
    .m00_axi_rresp  (rresp),
    .m00_axi_rvalid (rvalid),
    .m00_axi_rready (rready)
  );

  // Slave model, evaluated on the falling edge; readies rise one cycle after
  // valid plus an optional extra delay, B/R answer one cycle after handshake.
  int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0;
  int          b_err_reg = -1, rd_bad_reg = -1, r_err_reg = -1;
  logic [1:0]  b_err_resp = 2'b10;
  logic        b_hold = 1'b0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic        awv_prev = 1'b0, awr_prev = 1'b0, wv_prev = 1'b0, wr_prev = 1'b0;
  logic [31:0] aw_addr_cur = '0, w_data_cur = '0, ar_addr_cur = '0;
  logic [31:0] mem [16];
  logic [31:0] aw_log [16];
  logic [31:0] ar_log [16];
  int          done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
      awv_prev = 0; awr_prev = 0; wv_prev = 0; wr_prev = 0;
    end else begin
      // A valid must stay up until its handshake and drop right after it.
      if (awv_prev && (awr_prev == awvalid)) viol++;
      if (wv_prev && (wr_prev == wvalid)) viol++;
      if (bvalid) bvalid = 0;
      if (awready) awready = 0;
      else if (awvalid) begin
        if (aw_cnt > aw_dly) begin
          awready = 1; aw_cnt = 0; aw_got = 1; aw_addr_cur = awaddr;
          if (aw_hs < 16) aw_log[aw_hs] = awaddr;
          aw_hs++;
        end else aw_cnt++;
      end
      if (wready) wready = 0;
      else if (wvalid) begin
        if (w_cnt > w_dly) begin
          wready = 1; w_cnt = 0; w_got = 1; w_data_cur = wdata; w_hs++;
        end else w_cnt++;
      end
      if (aw_got && w_got && !awready && !wready && !b_hold) begin
        mem[aw_addr_cur[5:2]] = w_data_cur;
        bresp = (int'(aw_addr_cur[5:2]) == b_err_reg) ? b_err_resp : RESP_OKAY;
        bvalid = 1; aw_got = 0; w_got = 0;
      end
      if (rvalid) rvalid = 0;
      if (arready) begin
        arready = 0; rvalid = 1;
        rdata = (int'(ar_addr_cur[5:2]) == rd_bad_reg) ? 32'hABCD_0000 : mem[ar_addr_cur[5:2]];
        rresp = (int'(ar_addr_cur[5:2]) == r_err_reg) ? 2'b10 : RESP_OKAY;
      end else if (arvalid) begin
        arready = 1; ar_addr_cur = araddr;
        if (ar_hs < 16) ar_log[ar_hs] = araddr;
        ar_hs++;
      end
      awv_prev = awvalid; awr_prev = awready; wv_prev = wvalid; wr_prev = wready;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  int checks = 0, passes = 0, fails = 0;
  int cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    #2;
    aw_hs = 0; w_hs = 0; ar_hs = 0; viol = 0; done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  // cyc is the number of rising edges after the one that accepted start.
  task automatic run_seq(input logic v, input int restart_at, output int c);
    @(negedge clk);
    verify_en = v; start = 1'b1;
    c = -1;
    while (c < 300) begin
      @(negedge clk);
      c++;
      start = (c == restart_at);
      if (c == restart_at) base_addr = 32'h1000_0000;
      if (done || error) break;
    end
    start = 1'b0;
    base_addr = BASE;
    if (c >= 300) check("seq_timeout", 64'(c), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_w[0] = 32'h0101_FFFF; exp_w[1] = 32'hABCD_0001;
    exp_w[2] = 32'hDEAD_0011; exp_w[3] = 32'hBEEF_0011;
    cfg_data = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};

    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
    check("rst_addr", {awaddr, araddr}, 64'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_err", {err_code, err_index}, 6'd0);
    check("rst_const", {wstrb, awprot, arprot}, 10'h3C0);
    rst_n = 1'b1;

    // Plain write sequence
    clear_log();
    run_seq(1'b0, -1, cyc);
    check("t1_cycles", cyc, 16);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_aw_hs", aw_hs, 4);
    check("t1_ar_hs", ar_hs, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_awaddr", aw_log[i], BASE + 32'(4 * i));
      check("t1_mem", mem[i], exp_w[i]);
    end
    check("t1_busy_after", busy, 1'b0);

    // Write with readback
    clear_log();
    run_seq(1'b1, -1, cyc);
    check("t2_cycles", cyc, 24);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_err_cnt", err_cnt, 0);
    check("t2_err_code", err_code, 2'd0);
    check("t2_ar_hs", ar_hs, 4);
    for (int i = 0; i < 4; i++) check("t2_araddr", ar_log[i], BASE + 32'(4 * i));

    // Staggered AW/W readiness, both orders
    for (int k = 0; k < 2; k++) begin
      aw_dly = (k == 0) ? 3 : 1;
      w_dly  = (k == 0) ? 1 : 3;
      clear_log();
      run_seq(1'b0, -1, cyc);
      check("t3_done_cnt", done_cnt, 1);
      check("t3_aw_hs", aw_hs, 4);
      check("t3_w_hs", w_hs, 4);
      check("t3_valid_drop", viol, 0);
      check("t3_mem3", mem[3], exp_w[3]);
    end
    aw_dly = 0; w_dly = 0;

    // SLVERR on register 2
    b_err_reg = 2; b_err_resp = 2'b10;
    clear_log();
    run_seq(1'b0, -1, cyc);
    check("t4_cycles", cyc, 11);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_done_cnt", done_cnt, 0);
    check("t4_err_code", err_code, ERR_BRESP);
    check("t4_err_index", err_index, 4'd2);
    check("t4_aw_hs", aw_hs, 3);
    check("t4_busy", busy, 1'b0);

    // EXOKAY is not accepted either
    b_err_reg = 0; b_err_resp = RESP_EXOKAY;
    clear_log();
    run_seq(1'b0, -1, cyc);
    check("t4b_err_code", err_code, ERR_BRESP);
    check("t4b_err_index", err_index, 4'd0);
    check("t4b_aw_hs", aw_hs, 1);
    b_err_reg = -1;

    // Corrupted readback of register 1
    rd_bad_reg = 1;
    clear_log();
    run_seq(1'b1, -1, cyc);
    check("t5_cycles", cyc, 11);
    check("t5_err_cnt", err_cnt, 1);
    check("t5_err_code", err_code, ERR_MISMATCH);
    check("t5_err_index", err_index, 4'd1);
    check("t5_ar_hs", ar_hs, 2);
    rd_bad_reg = -1;

    // Bad RRESP on register 3
    r_err_reg = 3;
    clear_log();
    run_seq(1'b1, -1, cyc);
    check("t5b_cycles", cyc, 23);
    check("t5b_err_code", err_code, ERR_RRESP);
    check("t5b_err_index", err_index, 4'd3);
    r_err_reg = -1;

    // Second start while busy (with a different base) is ignored
    clear_log();
    run_seq(1'b0, 5, cyc);
    check("t6_cycles", cyc, 16);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_aw_hs", aw_hs, 4);
    check("t6_awaddr3", aw_log[3], BASE + 32'hC);
    check("t6_err_code", err_code, 2'd0);

    // Reset while waiting for the write response
    b_hold = 1'b1;
    clear_log();
    @(negedge clk);
    verify_en = 1'b0; start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bready) break;
    end
    check("t7_wresp_reached", bready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_outputs", {awvalid, wvalid, arvalid, bready, rready, busy, done, error}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b_hold = 1'b0;
    clear_log();
    run_seq(1'b1, -1, cyc);
    check("t7_cycles", cyc, 24);
    check("t7_done_cnt", done_cnt, 1);
    check("t7_ar_hs", ar_hs, 4);
    check("t7_mem0", mem[0], exp_w[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
